// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states and
// small opcode-classification helpers used by the MDU and the decoder.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_OP_NONE  = 4'd0,
        MDU_OP_MULT  = 4'd1,
        MDU_OP_MULTU = 4'd2,
        MDU_OP_DIV   = 4'd3,
        MDU_OP_DIVU  = 4'd4,
        MDU_OP_MADD  = 4'd5,
        MDU_OP_MADDU = 4'd6,
        MDU_OP_MSUB  = 4'd7,
        MDU_OP_MSUBU = 4'd8,
        MDU_OP_MTHI  = 4'd9,
        MDU_OP_MTLO  = 4'd10
    } mdu_op_e;

    typedef enum logic [0:0] {
        MDU_ST_IDLE = 1'b0,
        MDU_ST_RUN  = 1'b1
    } mdu_state_e;

    // True for opcodes that occupy the unit for a multi-cycle run.
    function automatic logic mdu_is_launch(input logic [MDU_OP_W-1:0] op);
        logic res;
        case (op)
            MDU_OP_MULT, MDU_OP_MULTU,
            MDU_OP_DIV,  MDU_OP_DIVU,
            MDU_OP_MADD, MDU_OP_MADDU,
            MDU_OP_MSUB, MDU_OP_MSUBU: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

    // True for the divide class, which uses the longer latency.
    function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
        logic res;
        case (op)
            MDU_OP_DIV, MDU_OP_DIVU: res = 1'b1;
            default:                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Latency comes from a
// down-counter; the arithmetic is evaluated on the latched operands at commit.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [WIDTH-1:0]    src_a,
    input  logic [WIDTH-1:0]    src_b,
    input  logic                cancel,
    output logic                busy,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int W2        = 2 * WIDTH;
    localparam int MAX_CYC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    mdu_state_e          state_r;
    logic [CNT_W-1:0]    cnt_r;
    mdu_op_e             op_r;
    logic [WIDTH-1:0]    op_a_r;
    logic [WIDTH-1:0]    op_b_r;
    logic [WIDTH-1:0]    hi_r;
    logic [WIDTH-1:0]    lo_r;

    logic [W2-1:0]       a_ux_s;
    logic [W2-1:0]       b_ux_s;
    logic [W2-1:0]       a_sx_s;
    logic [W2-1:0]       b_sx_s;
    logic [W2-1:0]       prod_u_s;
    logic [W2-1:0]       prod_s_s;
    logic [W2-1:0]       acc_s;

    logic                div_zero_s;
    logic                div_ovf_s;
    logic [WIDTH-1:0]    div_b_safe_s;
    logic signed [WIDTH-1:0] sdiv_a_s;
    logic signed [WIDTH-1:0] sdiv_b_s;
    logic signed [WIDTH-1:0] squot_s;
    logic signed [WIDTH-1:0] srem_s;
    logic [WIDTH-1:0]    uquot_s;
    logic [WIDTH-1:0]    urem_s;

    logic [WIDTH-1:0]    res_hi_s;
    logic [WIDTH-1:0]    res_lo_s;
    logic                res_we_s;
    logic                launch_s;
    logic                mt_ok_s;

    // Width-extended operands and full-width products; the low 2*WIDTH bits of
    // the sign-extended product equal the signed product modulo 2^(2*WIDTH).
    assign a_ux_s   = {{WIDTH{1'b0}}, op_a_r};
    assign b_ux_s   = {{WIDTH{1'b0}}, op_b_r};
    assign a_sx_s   = {{WIDTH{op_a_r[WIDTH-1]}}, op_a_r};
    assign b_sx_s   = {{WIDTH{op_b_r[WIDTH-1]}}, op_b_r};
    assign prod_u_s = a_ux_s * b_ux_s;
    assign prod_s_s = a_sx_s * b_sx_s;
    assign acc_s    = {hi_r, lo_r};

    // Divider inputs; the divisor is forced to 1 in the cases the result is not
    // taken from the divider, so no trapping operation is ever evaluated.
    assign div_zero_s   = (op_b_r == {WIDTH{1'b0}});
    assign div_ovf_s    = (op_a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_r == {WIDTH{1'b1}});
    assign div_b_safe_s = (div_zero_s || div_ovf_s) ? {{(WIDTH-1){1'b0}}, 1'b1} : op_b_r;
    assign sdiv_a_s     = op_a_r;
    assign sdiv_b_s     = div_b_safe_s;
    assign squot_s      = sdiv_a_s / sdiv_b_s;
    assign srem_s       = sdiv_a_s % sdiv_b_s;
    assign uquot_s      = op_a_r / div_b_safe_s;
    assign urem_s       = op_a_r % div_b_safe_s;

    // Commit value selection for the op currently in flight.
    always_comb begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        res_we_s = 1'b0;
        case (op_r)
            MDU_OP_MULT: begin
                {res_hi_s, res_lo_s} = prod_s_s;
                res_we_s = 1'b1;
            end
            MDU_OP_MULTU: begin
                {res_hi_s, res_lo_s} = prod_u_s;
                res_we_s = 1'b1;
            end
            MDU_OP_MADD: begin
                {res_hi_s, res_lo_s} = acc_s + prod_s_s;
                res_we_s = 1'b1;
            end
            MDU_OP_MADDU: begin
                {res_hi_s, res_lo_s} = acc_s + prod_u_s;
                res_we_s = 1'b1;
            end
            MDU_OP_MSUB: begin
                {res_hi_s, res_lo_s} = acc_s - prod_s_s;
                res_we_s = 1'b1;
            end
            MDU_OP_MSUBU: begin
                {res_hi_s, res_lo_s} = acc_s - prod_u_s;
                res_we_s = 1'b1;
            end
            MDU_OP_DIV: begin
                if (div_zero_s) begin
                    res_we_s = 1'b0;
                end else if (div_ovf_s) begin
                    res_lo_s = op_a_r;
                    res_hi_s = {WIDTH{1'b0}};
                    res_we_s = 1'b1;
                end else begin
                    res_lo_s = squot_s;
                    res_hi_s = srem_s;
                    res_we_s = 1'b1;
                end
            end
            MDU_OP_DIVU: begin
                if (div_zero_s) begin
                    res_we_s = 1'b0;
                end else begin
                    res_lo_s = uquot_s;
                    res_hi_s = urem_s;
                    res_we_s = 1'b1;
                end
            end
            default: begin
                res_we_s = 1'b0;
            end
        endcase
    end

    // Launch qualification; a flushed E stage must not write HI/LO either.
    always_comb begin
        launch_s = 1'b0;
        mt_ok_s  = 1'b0;
        if (state_r == MDU_ST_IDLE && !cancel) begin
            launch_s = start && mdu_is_launch(mdu_op);
            mt_ok_s  = !start;
        end else begin
            launch_s = 1'b0;
            mt_ok_s  = 1'b0;
        end
    end

    // FSM, latency counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= MDU_ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= MDU_OP_NONE;
            op_a_r  <= {WIDTH{1'b0}};
            op_b_r  <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                MDU_ST_IDLE: begin
                    if (launch_s) begin
                        op_r    <= mdu_op_e'(mdu_op);
                        op_a_r  <= src_a;
                        op_b_r  <= src_b;
                        cnt_r   <= mdu_is_div(mdu_op) ? CNT_W'(DIV_CYCLES - 1)
                                                      : CNT_W'(MULT_CYCLES - 1);
                        state_r <= MDU_ST_RUN;
                    end else if (mt_ok_s && mdu_op == MDU_OP_MTHI) begin
                        hi_r <= src_a;
                    end else if (mt_ok_s && mdu_op == MDU_OP_MTLO) begin
                        lo_r <= src_a;
                    end
                end
                MDU_ST_RUN: begin
                    if (cancel) begin
                        state_r <= MDU_ST_IDLE;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        if (res_we_s) begin
                            hi_r <= res_hi_s;
                            lo_r <= res_lo_s;
                        end
                        state_r <= MDU_ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= MDU_ST_IDLE;
                end
            endcase
        end
    end

    assign busy = start | (state_r == MDU_ST_RUN);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
